// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO write unit: op codes, FSM states and default widths.
// Consumed by hilo_write_unit_if, hilo_accum and hilo_write_unit.
package hilo_pkg;

  localparam int W_HALF = 32;
  localparam int OP_W   = 3;

  // Codes 7 and above are undefined and treated as NOP.
  typedef enum logic [OP_W-1:0] {
    HILO_NOP     = 3'd0,
    HILO_WRITE64 = 3'd1,
    HILO_MTHI    = 3'd2,
    HILO_MTLO    = 3'd3,
    HILO_MADD    = 3'd4,
    HILO_MSUB    = 3'd5,
    HILO_CLR     = 3'd6
  } hilo_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } hilo_state_e;

endpackage

// File: rtl/hilo_write_unit_if.sv
// EX-stage bus between the operand select / pipeline control and the HI/LO write unit.
// master = pipeline side, slave = hilo_write_unit.
interface hilo_write_unit_if #(
  parameter int W_HALF = hilo_pkg::W_HALF
);
  import hilo_pkg::*;

  logic                  Valid;
  logic [OP_W-1:0]       Op;
  logic [2*W_HALF-1:0]   Prod;
  logic [W_HALF-1:0]     RsData;
  logic                  Stall;
  logic                  Busy;
  logic                  Done;
  logic [W_HALF-1:0]     Hi;
  logic [W_HALF-1:0]     Lo;
  logic [2*W_HALF-1:0]   HiLo;

  modport master (
    output Valid, Op, Prod, RsData, Stall,
    input  Busy, Done, Hi, Lo, HiLo
  );

  modport slave (
    input  Valid, Op, Prod, RsData, Stall,
    output Busy, Done, Hi, Lo, HiLo
  );

endinterface

// File: rtl/hilo_accum.sv
// Combinational add/sub used for the MADD/MSUB second cycle.
// Wraps modulo 2^W; no carry or overflow is reported.
module hilo_accum #(
  parameter int W = 64
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] operand,
  input  logic         sub,
  output logic [W-1:0] result
);

  always_comb begin
    if (sub) result = acc - operand;
    else     result = acc + operand;
  end

endmodule

// File: rtl/hilo_write_unit.sv
// HI/LO special-register write unit: WRITE64, MTHI/MTLO, CLR and two-cycle MADD/MSUB.
// Optional macro HILO_FWD_EN bypasses the value being committed onto Hi/Lo/HiLo.
//
//   state   | meaning
//   ST_IDLE | accepting ops; single-cycle ops commit on the next edge
//   ST_ACC  | accumulate in flight; Busy=1, commits latched operand next edge
module hilo_write_unit
  import hilo_pkg::*;
#(
  parameter int W_HALF = hilo_pkg::W_HALF
) (
  input  logic              Clk,
  input  logic              Rst,
  hilo_write_unit_if.slave  bus
);

  localparam int W_FULL = 2 * W_HALF;

  hilo_state_e       state_q, state_nxt;
  logic [W_FULL-1:0] hilo_q, hilo_nxt;
  logic [W_FULL-1:0] lat_q;
  logic              sub_q;
  logic              done_q;
  logic [W_FULL-1:0] acc_res;
  logic [W_FULL-1:0] hilo_vis;
  logic              commit;
  logic              latch_en;

  hilo_accum #(.W(W_FULL)) u_accum (
    .acc     (hilo_q),
    .operand (lat_q),
    .sub     (sub_q),
    .result  (acc_res)
  );

  // Stall suppresses everything, so hilo_nxt == hilo_q and commit == 0 while frozen.
  always_comb begin
    state_nxt = state_q;
    hilo_nxt  = hilo_q;
    commit    = 1'b0;
    latch_en  = 1'b0;
    if (!bus.Stall) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.Valid) begin
            case (bus.Op)
              HILO_WRITE64: begin
                hilo_nxt = bus.Prod;
                commit   = 1'b1;
              end
              HILO_MTHI: begin
                hilo_nxt = {bus.RsData, hilo_q[W_HALF-1:0]};
                commit   = 1'b1;
              end
              HILO_MTLO: begin
                hilo_nxt = {hilo_q[W_FULL-1:W_HALF], bus.RsData};
                commit   = 1'b1;
              end
              HILO_MADD, HILO_MSUB: begin
                latch_en  = 1'b1;
                state_nxt = ST_ACC;
              end
              HILO_CLR: begin
                hilo_nxt = '0;
                commit   = 1'b1;
              end
              default: ;
            endcase
          end
        end
        // Valid is ignored here: a request during Busy is a protocol error and is dropped.
        ST_ACC: begin
          hilo_nxt  = acc_res;
          commit    = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      hilo_q  <= '0;
      lat_q   <= '0;
      sub_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      hilo_q  <= hilo_nxt;
      done_q  <= commit;
      if (latch_en) begin
        lat_q <= bus.Prod;
        sub_q <= (bus.Op == HILO_MSUB);
      end
    end
  end

`ifdef HILO_FWD_EN
  assign hilo_vis = hilo_nxt;
`else
  assign hilo_vis = hilo_q;
`endif

  assign bus.Busy = (state_q == ST_ACC);
  assign bus.Done = done_q;
  assign bus.Hi   = hilo_vis[W_FULL-1:W_HALF];
  assign bus.Lo   = hilo_vis[W_HALF-1:0];
  assign bus.HiLo = hilo_vis;

endmodule
